cam_reg_seq: RTL



---
 rtl/cam_reg_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cam_reg_seq.sv
// Camera register-init sequencer: walks a {dev,reg,data} table and
// issues one I2C write per entry to iic_drive, with delays and retries.
//
// Ports:
//   clk_i, rst          I2C control clock, async active-high reset
//   init_start          pulse, starts the table walk at entry 0
//   tbl_addr/tbl_data   registered-ROM read port (data 1 cycle later)
//   busy, err           status from iic_drive
//   start_en, wr_rd_flag, i2c_device_addr, register, data_byte
//                       command fields to iic_drive
//   config_busy/done/err, err_index
//                       sequence status
module cam_reg_seq #(
  parameter int TBL_AW       = 8,
  parameter int MAX_RETRY    = 3,
  parameter int TICKS_PER_MS = 100,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              init_start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [31:0]       tbl_data,
  input  logic              busy,
  input  logic              err,
  output logic              start_en,
  output logic              wr_rd_flag,
  output logic [7:0]        i2c_device_addr,
  output logic [15:0]       register,
  output logic [7:0]        data_byte,
  output logic              config_busy,
  output logic              config_done,
  output logic              config_err,
  output logic [TBL_AW-1:0] err_index
);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    WAIT_IDLE,
    KICK,
    WAIT_ACK,
    WAIT_END,
    CHECK,
    DELAY,
    NEXT,
    DONE,
    FAIL
  } state_t;

  state_t      state;
  logic [31:0] timer;
  logic [7:0]  retry;
  logic        fail_q;

  // Only writes are ever issued.
  assign wr_rd_flag = 1'b0;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      retry           <= '0;
      fail_q          <= 1'b0;
      tbl_addr        <= '0;
      start_en        <= 1'b0;
      i2c_device_addr <= '0;
      register        <= '0;
      data_byte       <= '0;
      config_busy     <= 1'b0;
      config_done     <= 1'b0;
      config_err      <= 1'b0;
      err_index       <= '0;
    end else begin
      start_en <= 1'b0;
      case (state)
        IDLE: begin
          if (init_start) begin
            tbl_addr    <= '0;
            retry       <= '0;
            config_busy <= 1'b1;
            config_done <= 1'b0;
            config_err  <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          i2c_device_addr <= tbl_data[31:24];
          register        <= tbl_data[23:8];
          data_byte       <= tbl_data[7:0];
          if (tbl_data[31:24] == 8'h00) begin
            state <= DONE;
          end else if (tbl_data[23:8] == 16'hFFFF) begin
            if (tbl_data[7:0] == 8'h00) begin
              state <= NEXT;
            end else begin
              // Terminal count 0 gives exactly N*TICKS cycles here.
              timer <= 32'(tbl_data[7:0]) * 32'(TICKS_PER_MS) - 32'd1;
              state <= DELAY;
            end
          end else begin
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (!busy) begin
            start_en <= 1'b1;
            state    <= KICK;
          end
        end
        KICK: begin
          timer <= 32'(ACK_TIMEOUT - 1);
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (busy) begin
            state <= WAIT_END;
          end else if (timer == 32'd0) begin
            // No acknowledge: same outcome as a NAKed write.
            fail_q <= 1'b1;
            state  <= CHECK;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        WAIT_END: begin
          if (!busy) begin
            fail_q <= err;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (!fail_q) begin
            retry <= '0;
            state <= NEXT;
          end else if (retry < 8'(MAX_RETRY)) begin
            retry <= retry + 8'd1;
            state <= WAIT_IDLE;
          end else begin
            err_index <= tbl_addr;
            state     <= FAIL;
          end
        end
        DELAY: begin
          if (timer == 32'd0) state <= NEXT;
          else timer <= timer - 32'd1;
        end
        NEXT: begin
          // Running off the end of the table counts as success.
          if (&tbl_addr) begin
            state <= DONE;
          end else begin
            tbl_addr <= tbl_addr + 1'b1;
            state    <= FETCH;
          end
        end
        DONE: begin
          config_done <= 1'b1;
          config_busy <= 1'b0;
          state       <= IDLE;
        end
        FAIL: begin
          config_err  <= 1'b1;
          config_busy <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
